// File: rtl/cci_mpf_drain_ctrl.sv
// Quiesce controller for the AFU side of the null MPF shim: blocks new TX traffic,
// waits for TX silence, optionally fences writes, then waits for the shim to empty.
module cci_mpf_drain_ctrl #(
  parameter int QUIET_CYCLES   = 8,
  parameter int EMPTY_SETTLE   = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int ISSUE_WRFENCE  = 1,
  parameter int CYCLE_CNT_W    = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   drain_req,
  input  logic                   c0TxValid,
  input  logic                   c1TxValid,
  input  logic                   c0TxAlmFullIn,
  input  logic                   c1TxAlmFullIn,
  input  logic                   c0NotEmpty,
  input  logic                   c1NotEmpty,
  input  logic                   fence_ack,
  output logic                   c0TxAlmFull,
  output logic                   c1TxAlmFull,
  output logic                   fence_req,
  output logic                   drain_busy,
  output logic                   drain_done,
  output logic                   drain_timeout,
  output logic [CYCLE_CNT_W-1:0] drain_cycles
);

  localparam int QW = $clog2(QUIET_CYCLES) + 1;
  localparam int SW = $clog2(EMPTY_SETTLE) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_FENCE, S_WAIT_EMPTY, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [QW-1:0]          r_quiet_cnt;
  logic [SW-1:0]          r_settle_cnt;
  logic [TW-1:0]          r_tmo_cnt;
  logic                   w_active;
  logic                   w_start;
  logic                   w_tx_quiet;
  logic                   w_empty;
  logic                   w_quiet_hit;
  logic                   w_settle_hit;
  logic                   w_tmo_hit;
  logic                   w_success;
  logic                   w_tmo;

  assign w_active     = (r_state == S_QUIESCE) || (r_state == S_FENCE) ||
                        (r_state == S_WAIT_EMPTY);
  assign w_start      = (r_state == S_IDLE) && drain_req;
  assign w_tx_quiet   = ~c0TxValid & ~c1TxValid;
  assign w_empty      = ~c0NotEmpty & ~c1NotEmpty;
  assign w_quiet_hit  = w_tx_quiet && (r_quiet_cnt == QW'(QUIET_CYCLES - 1));
  assign w_settle_hit = w_empty && (r_settle_cnt == SW'(EMPTY_SETTLE - 1));
  // The current cycle is the TIMEOUT_CYCLES-th active one once the count reaches limit-1.
  assign w_tmo_hit    = (r_tmo_cnt >= TW'(TIMEOUT_CYCLES - 1));

  assign c0TxAlmFull = c0TxAlmFullIn | (r_state != S_IDLE);
  assign c1TxAlmFull = c1TxAlmFullIn | (r_state != S_IDLE);

  always_comb begin
    w_next    = r_state;
    w_success = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_IDLE: if (drain_req) w_next = S_QUIESCE;
      S_QUIESCE: begin
        if (!drain_req)       w_next = S_IDLE;
        else if (w_quiet_hit) w_next = (ISSUE_WRFENCE != 0) ? S_FENCE : S_WAIT_EMPTY;
        else if (w_tmo_hit) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      // The fence handshake is never broken; abort and timeout wait for the ack.
      S_FENCE: begin
        if (fence_ack) begin
          if (!drain_req) w_next = S_IDLE;
          else if (w_tmo_hit) begin
            w_next = S_DONE;
            w_tmo  = 1'b1;
          end else w_next = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        if (!drain_req) w_next = S_IDLE;
        else if (w_settle_hit) begin
          w_next    = S_DONE;
          w_success = 1'b1;
        end else if (w_tmo_hit) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE: if (!drain_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_quiet_cnt   <= '0;
      r_settle_cnt  <= '0;
      r_tmo_cnt     <= '0;
      fence_req     <= 1'b0;
      drain_busy    <= 1'b0;
      drain_done    <= 1'b0;
      drain_timeout <= 1'b0;
      drain_cycles  <= '0;
    end else begin
      r_state      <= w_next;
      r_quiet_cnt  <= (r_state == S_QUIESCE && w_tx_quiet) ? r_quiet_cnt + 1'b1 : '0;
      r_settle_cnt <= (r_state == S_WAIT_EMPTY && w_empty) ? r_settle_cnt + 1'b1 : '0;
      if (r_state == S_IDLE) r_tmo_cnt <= '0;
      else if (w_active && r_tmo_cnt != TW'(TIMEOUT_CYCLES)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_start) drain_cycles <= '0;
      else if (w_active && !(&drain_cycles)) drain_cycles <= drain_cycles + 1'b1;
      fence_req  <= (w_next == S_FENCE);
      drain_busy <= (w_next != S_IDLE);
      if (w_next == S_IDLE) drain_done <= 1'b0;
      else if (w_success)   drain_done <= 1'b1;
      if (w_start)    drain_timeout <= 1'b0;
      else if (w_tmo) drain_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_drain_ctrl.sv
// Directed bench for cci_mpf_drain_ctrl: default instance A and a no-fence,
// short-timeout instance B share the same stimulus.
module tb_cci_mpf_drain_ctrl;

  logic clk = 1'b0;
  logic reset_n, drain_req, c0v, c1v, c0af_in, c1af_in, c0ne, c1ne, fence_ack;
  logic a_c0af, a_c1af, a_fr, a_busy, a_done, a_to;
  logic b_c0af, b_c1af, b_fr, b_busy, b_done, b_to;
  logic [19:0] a_dc, b_dc;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int a_af_first, a_fr_first, a_fr_last, a_done_first, a_dc_done, a_idle_first;
  int b_to_first, b_done_first, b_dc_to;

  always #5 clk = ~clk;

  cci_mpf_drain_ctrl u_a (
    .clk(clk), .reset_n(reset_n), .drain_req(drain_req), .c0TxValid(c0v), .c1TxValid(c1v),
    .c0TxAlmFullIn(c0af_in), .c1TxAlmFullIn(c1af_in), .c0NotEmpty(c0ne), .c1NotEmpty(c1ne),
    .fence_ack(fence_ack), .c0TxAlmFull(a_c0af), .c1TxAlmFull(a_c1af), .fence_req(a_fr),
    .drain_busy(a_busy), .drain_done(a_done), .drain_timeout(a_to), .drain_cycles(a_dc));

  cci_mpf_drain_ctrl #(.TIMEOUT_CYCLES(100), .ISSUE_WRFENCE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .drain_req(drain_req), .c0TxValid(c0v), .c1TxValid(c1v),
    .c0TxAlmFullIn(c0af_in), .c1TxAlmFullIn(c1af_in), .c0NotEmpty(c0ne), .c1NotEmpty(c1ne),
    .fence_ack(fence_ack), .c0TxAlmFull(b_c0af), .c1TxAlmFull(b_c1af), .fence_req(b_fr),
    .drain_busy(b_busy), .drain_done(b_done), .drain_timeout(b_to), .drain_cycles(b_dc));

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; drain_req = 1'b0; c0v = 1'b0; c1v = 1'b0; c0af_in = 1'b0;
    c1af_in = 1'b0; c0ne = 1'b0; c1ne = 1'b0; fence_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Drive drain_req=1 at cycle 0, then observe cycles 1..ncyc.
  task automatic run(input int ack_c, input int v1_c, input int drop_c, input int ncyc);
    a_af_first = -1; a_fr_first = -1; a_fr_last = -1; a_done_first = -1; a_dc_done = -1;
    a_idle_first = -1; b_to_first = -1; b_done_first = -1; b_dc_to = -1;
    cyc = 0;
    drain_req = 1'b1; fence_ack = 1'b0; c1v = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (a_c0af && a_af_first < 0) a_af_first = cyc;
      if (!a_c0af && a_af_first >= 0 && a_idle_first < 0) a_idle_first = cyc;
      if (a_fr) begin
        if (a_fr_first < 0) a_fr_first = cyc;
        a_fr_last = cyc;
      end
      if (a_done && a_done_first < 0) begin
        a_done_first = cyc;
        a_dc_done = int'(a_dc);
      end
      if (b_to && b_to_first < 0) begin
        b_to_first = cyc;
        b_dc_to = int'(b_dc);
      end
      if (b_done && b_done_first < 0) b_done_first = cyc;
      drain_req = (c < drop_c);
      fence_ack = (c == ack_c);
      c1v = (c == v1_c);
    end
  endtask

  task automatic basic_checks(input string s);
    chk({s, "_af_first"}, a_af_first, 1);
    chk({s, "_fr_first"}, a_fr_first, 9);
    chk({s, "_fr_last"}, a_fr_last, 11);
    chk({s, "_done_cyc"}, a_done_first, 16);
    chk({s, "_drain_cycles"}, a_dc_done, 15);
    chk({s, "_timeout"}, int'(a_to), 0);
  endtask

  initial begin
    cyc = 0;
    do_reset();
    c0af_in = 1'b1;
    #1;
    chk("rst_c0af_pass", int'(a_c0af), 1);
    chk("rst_c1af_pass", int'(a_c1af), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_fence_req", int'(a_fr), 0);
    chk("rst_dc", int'(a_dc), 0);
    c0af_in = 1'b0;

    // Basic drain with fence ack at cycle 11.
    run(11, -1, 1000, 20);
    basic_checks("s1");
    chk("s1_busy", int'(a_busy), 1);
    drain_req = 1'b0;
    tick(); tick();
    chk("s1_rel_busy", int'(a_busy), 0);
    chk("s1_rel_done", int'(a_done), 0);
    chk("s1_rel_af", int'(a_c0af), 0);

    // TX valid at cycle 5 restarts the quiet window.
    do_reset();
    run(16, 5, 1000, 25);
    chk("s2_fr_first", a_fr_first, 14);
    chk("s2_done_cyc", a_done_first, 21);
    chk("s2_drain_cycles", a_dc_done, 20);

    // Timeout while a read stays outstanding (instance B).
    do_reset();
    c0ne = 1'b1;
    run(-1, -1, 1000, 110);
    chk("s3_to_cyc", b_to_first, 101);
    chk("s3_done_never", b_done_first, -1);
    chk("s3_drain_cycles", b_dc_to, 100);
    drain_req = 1'b0;
    tick(); tick();
    chk("s3_rel_busy", int'(b_busy), 0);
    chk("s3_rel_to_sticky", int'(b_to), 1);
    chk("s3_rel_af", int'(b_c1af), 0);
    c0ne = 1'b0;

    // Abort during QUIESCE.
    do_reset();
    run(-1, -1, 4, 10);
    chk("s4_af_first", a_af_first, 1);
    chk("s4_idle_cyc", a_idle_first, 5);
    chk("s4_done_never", a_done_first, -1);
    chk("s4_busy_end", int'(a_busy), 0);

    // Abort during FENCE waits for the ack.
    do_reset();
    run(13, -1, 10, 18);
    chk("s5_fr_first", a_fr_first, 9);
    chk("s5_fr_last", a_fr_last, 13);
    chk("s5_idle_cyc", a_idle_first, 14);
    chk("s5_done_never", a_done_first, -1);

    // Asynchronous reset in WAIT_EMPTY, then a fresh drain.
    do_reset();
    c1ne = 1'b1;
    run(11, -1, 1000, 13);
    chk("s6_pre_busy", int'(a_busy), 1);
    c1af_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_rst_busy", int'(a_busy), 0);
    chk("s6_rst_dc", int'(a_dc), 0);
    chk("s6_rst_c0af", int'(a_c0af), 0);
    chk("s6_rst_c1af", int'(a_c1af), 1);
    chk("s6_rst_fr", int'(a_fr), 0);
    do_reset();
    run(11, -1, 1000, 20);
    basic_checks("s6");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
